ppu_phase_controller: RTL
=========================

// Module: ppu_phase_controller
// PURPOSE
//  Sequences one PPU tile cycle: halo exchange -> drain neighbour inputs -> accumulate/ReLU/compress -> commit.
//  Owns the single activation-buffer read port, granting it to output_partials or output_accumulator by phase.
//  Aggregates neighbour exchange status and flags hung exchanges with a watchdog.
//  Sits inside ppu between the channel-group sequencer and the partials/accumulator sub-blocks.
// PARAMETERS
//  BANK_COUNT     256    activation-buffer banks; read-bank select width = $clog2(BANK_COUNT)
//  TILE_SIZE      256    max tile edge; entry select width = $clog2(TILE_SIZE)
//  TIMEOUT_CYCLES 65535  max cycles in EXCHANGE+DRAIN before error; counter width $clog2(TIMEOUT_CYCLES+1)
// PORTS
//  clk                    in   1   clock, single domain
//  reset_n                in   1   asynchronous active-low reset
//  channel_group_done     in   1   start pulse: channel-group partials are final
//  partial_exchange_done  in   1   output_partials finished sending halo
//  neighbor_exchange_done in   8   per-neighbour done level (N,NE,E,SE,S,SW,W,NW)
//  leftover_inputs        in   1   neighbour_input_processor still holds unwritten inputs
//  accumulate_done        in   1   output_accumulator reached end of tile (level)
//  partial_bank_read      in   $clog2(BANK_COUNT)  partials read bank
//  partial_bank_entry     in   $clog2(TILE_SIZE)   partials read entry
//  accum_bank_read        in   $clog2(BANK_COUNT)  accumulator read bank
//  accum_bank_entry       in   $clog2(TILE_SIZE)   accumulator read entry
//  buffer_bank_read       out  $clog2(BANK_COUNT)  muxed read bank
//  buffer_bank_entry      out  $clog2(TILE_SIZE)   muxed read entry
//  partial_start          out  1   1-cycle pulse launching output_partials
//  accum_enable           out  1   level; high only in ACCUMULATE (accumulator held in reset otherwise)
//  phase                  out  3   ppu_pkg::phase_t current state
//  tile_done              out  1   1-cycle pulse in COMMIT
//  timeout_error          out  1   sticky; cleared only by reset_n
//  overrun                out  1   sticky; channel_group_done seen while not IDLE
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, nbr_seen mask 0, watchdog 0; grant = partials.
//  States: IDLE -> EXCHANGE -> DRAIN -> ACCUMULATE -> COMMIT -> IDLE.
//  IDLE: on channel_group_done -> EXCHANGE; partial_start pulses the cycle after (registered).
//  EXCHANGE: grant partials; nbr_seen |= neighbor_exchange_done each cycle;
//    partial_exchange_done -> DRAIN.
//  DRAIN: grant partials; keep OR-ing nbr_seen; -> ACCUMULATE when (&nbr_seen_next) && !leftover_inputs
//    in same cycle. Neighbour done may arrive before own done; it is remembered.
//  ACCUMULATE: grant accumulator; accum_enable=1; accumulate_done -> COMMIT.
//  COMMIT: tile_done=1 for exactly one cycle; clear nbr_seen; -> IDLE.
//  Read mux: combinational from registered grant; zero added latency; no glitch on phase edges
//    since grant changes only on clock edges.
//  Watchdog: cleared on entering EXCHANGE, +1 per cycle in EXCHANGE/DRAIN, saturating.
//    Reaching TIMEOUT_CYCLES: timeout_error<=1, state -> IDLE, nbr_seen cleared, no tile_done.
//  channel_group_done outside IDLE: ignored, overrun<=1. Same-cycle as COMMIT: ignored (overrun set).
//  accumulate_done outside ACCUMULATE: ignored. partial_exchange_done outside EXCHANGE: ignored.
//  reset_n low mid-tile: immediate return to reset values; accumulator sees accum_enable=0.
// STRUCTURE
//  ppu_pkg: typedef enum logic[2:0] phase_t {IDLE=0,EXCHANGE=1,DRAIN=2,ACCUMULATE=3,COMMIT=4};
//    localparam NEIGHBOR_COUNT=8; grant_t {GRANT_PARTIAL=0,GRANT_ACCUM=1}.
//  One sub-module: ppu_watchdog (saturating counter, clear/enable in, expired out).
//  Integration: ppu drives accumulator reset from accum_enable instead of &neighbor_exchange_done.
// TESTING
//  1 Normal: start; own done @+20; neighbours all 8'hFF @+25; leftover 0 -> ACCUMULATE @+26,
//    buffer_bank_read follows accum_bank_read; accumulate_done @+100 -> tile_done one pulse @+101.
//  2 Staggered: neighbours set bits one per cycle before own done, then drop to 0 -> still enters
//    ACCUMULATE once partial_exchange_done and leftover_inputs=0.
//  3 Backpressure: all done but leftover_inputs=1 for 10 cycles -> stays DRAIN, grant partials; exits cycle after 0.
//  4 Timeout: TIMEOUT_CYCLES=16, neighbour bit 3 never set -> timeout_error=1 at cycle 16, phase IDLE, no tile_done.
//  5 Overrun: channel_group_done during ACCUMULATE -> overrun=1, phase unchanged, tile completes normally.
//  6 Async reset mid-ACCUMULATE -> phase=0, accum_enable=0, grant partials same instant; new start works.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared types for the PPU tile-cycle controller: phase encoding and read-port grant.
package ppu_pkg;

  localparam int NEIGHBOR_COUNT = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    EXCHANGE   = 3'd1,
    DRAIN      = 3'd2,
    ACCUMULATE = 3'd3,
    COMMIT     = 3'd4
  } phase_t;

  typedef enum logic {
    GRANT_PARTIAL = 1'b0,
    GRANT_ACCUM   = 1'b1
  } grant_t;

endpackage

// File: rtl/ppu_watchdog.sv
// Saturating cycle counter guarding the halo exchange. expired fires on the
// TIMEOUT_CYCLES-th enabled cycle after a clear.
module ppu_watchdog #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] SAT  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  // Next count: clear wins, otherwise count enabled cycles up to saturation.
  always_comb begin
    count_d = count_q;
    if (clear)                        count_d = '0;
    else if (enable && count_q != SAT) count_d = count_q + CW'(1);
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  // count_q holds the number of enabled cycles already completed, so this is
  // the last allowed cycle.
  assign expired = enable && !clear && (count_q == LAST);

endmodule

// File: rtl/ppu_phase_controller.sv
// Sequences one PPU tile: exchange halo, drain neighbour inputs, accumulate,
// commit. Owns the activation-buffer read port and the exchange watchdog.
module ppu_phase_controller
  import ppu_pkg::*;
#(
  parameter int BANK_COUNT     = 256,
  parameter int TILE_SIZE      = 256,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          channel_group_done,
  input  logic                          partial_exchange_done,
  input  logic [NEIGHBOR_COUNT-1:0]     neighbor_exchange_done,
  input  logic                          leftover_inputs,
  input  logic                          accumulate_done,
  input  logic [$clog2(BANK_COUNT)-1:0] partial_bank_read,
  input  logic [$clog2(TILE_SIZE)-1:0]  partial_bank_entry,
  input  logic [$clog2(BANK_COUNT)-1:0] accum_bank_read,
  input  logic [$clog2(TILE_SIZE)-1:0]  accum_bank_entry,
  output logic [$clog2(BANK_COUNT)-1:0] buffer_bank_read,
  output logic [$clog2(TILE_SIZE)-1:0]  buffer_bank_entry,
  output logic                          partial_start,
  output logic                          accum_enable,
  output phase_t                        phase,
  output logic                          tile_done,
  output logic                          timeout_error,
  output logic                          overrun
);

  phase_t                    state_q, state_d;
  grant_t                    grant_q, grant_d;
  logic [NEIGHBOR_COUNT-1:0] nbr_seen_q, nbr_seen_d, nbr_next;
  logic                      partial_start_q, partial_start_d;
  logic                      timeout_error_q, timeout_error_d;
  logic                      overrun_q, overrun_d;
  logic                      wd_clear, wd_en, wd_expired;

  assign wd_clear = (state_q == IDLE) && channel_group_done;
  assign wd_en    = (state_q == EXCHANGE) || (state_q == DRAIN);
  // Neighbour done is a level that may drop again; remember every bit seen.
  assign nbr_next = nbr_seen_q | neighbor_exchange_done;

  ppu_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (wd_clear),
    .enable  (wd_en),
    .expired (wd_expired)
  );

  // Next phase, neighbour mask and sticky status; watchdog expiry overrides the sequence.
  always_comb begin
    state_d         = state_q;
    nbr_seen_d      = nbr_seen_q;
    partial_start_d = 1'b0;
    timeout_error_d = timeout_error_q;
    overrun_d       = overrun_q | (channel_group_done && state_q != IDLE);
    case (state_q)
      IDLE: if (channel_group_done) begin
        state_d         = EXCHANGE;
        partial_start_d = 1'b1;
      end
      EXCHANGE: begin
        nbr_seen_d = nbr_next;
        if (partial_exchange_done) state_d = DRAIN;
      end
      DRAIN: begin
        nbr_seen_d = nbr_next;
        if ((&nbr_next) && !leftover_inputs) state_d = ACCUMULATE;
      end
      ACCUMULATE: if (accumulate_done) state_d = COMMIT;
      COMMIT: begin
        nbr_seen_d = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (wd_expired) begin
      state_d         = IDLE;
      nbr_seen_d      = '0;
      timeout_error_d = 1'b1;
    end
    grant_d = (state_d == ACCUMULATE) ? GRANT_ACCUM : GRANT_PARTIAL;
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      grant_q         <= GRANT_PARTIAL;
      nbr_seen_q      <= '0;
      partial_start_q <= 1'b0;
      timeout_error_q <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      nbr_seen_q      <= nbr_seen_d;
      partial_start_q <= partial_start_d;
      timeout_error_q <= timeout_error_d;
      overrun_q       <= overrun_d;
    end
  end

  // Read port mux keyed by the registered grant, so it only switches on clock edges.
  assign buffer_bank_read  = (grant_q == GRANT_ACCUM) ? accum_bank_read  : partial_bank_read;
  assign buffer_bank_entry = (grant_q == GRANT_ACCUM) ? accum_bank_entry : partial_bank_entry;

  assign partial_start = partial_start_q;
  assign accum_enable  = (state_q == ACCUMULATE);
  assign tile_done     = (state_q == COMMIT);
  assign phase         = state_q;
  assign timeout_error = timeout_error_q;
  assign overrun       = overrun_q;

endmodule
